// File: rtl/fifo_stream_reader_pkg.sv
// Shared defaults and a width helper for the FIFO stream reader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_stream_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_LATENCY     = 3;
    localparam int DEF_EMPTY_GUARD = 2;
    localparam int COUNT_W         = 16;

    // Bits needed to hold values 0..max_val (always at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Upstream FIFO read port plus downstream valid/ready stream, bundled.
// Latency: n/a (signal bundle only).
// Backpressure: out_ready from the stream sink throttles the reader.
interface fifo_stream_reader_if
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  fifo_empty;
    logic                  fifo_read;
    logic [DATA_WIDTH-1:0] fifo_read_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    // Reader side: consumes the FIFO, produces the stream.
    modport master (
        input  fifo_empty,
        input  fifo_read_data,
        input  out_ready,
        output fifo_read,
        output out_valid,
        output out_data
    );

    // Environment side: the FIFO and the stream sink.
    modport slave (
        output fifo_empty,
        output fifo_read_data,
        output out_ready,
        input  fifo_read,
        input  out_valid,
        input  out_data
    );

endinterface

// File: rtl/fifo_stream_reader_buf.sv
// Circular skid buffer holding words returned by the FIFO until the sink takes them.
// Latency: a pushed word is visible at pop_data one cycle after the push edge.
// Backpressure: none internally; caller must never push when full or pop when empty.
module stream_out_buffer
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_LATENCY + 1,
    localparam int PTR_W     = cnt_width(DEPTH - 1),
    localparam int OCC_W     = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [OCC_W-1:0]      occupancy
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_data = mem[head];

    // Pointer and occupancy bookkeeping; push+pop together leaves occupancy unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            if (push) tail <= ptr_next(tail);
            if (pop)  head <= ptr_next(head);
            if (push && !pop)
                occupancy <= occupancy + OCC_W'(1);
            else if (pop && !push)
                occupancy <= occupancy - OCC_W'(1);
        end
    end

    // Data storage carries no reset; stale entries are never visible since occupancy gates them.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= push_data;
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Turns a fixed-latency FIFO read port into a valid/ready stream (optional out_count via FIFO_STREAM_READER_COUNT_EN).
// Latency: first word LATENCY+EMPTY_GUARD+1 cycles after fifo_empty falls, then one word per cycle.
// Backpressure: reads are issued only while inflight+buffered words fit the LATENCY+1 buffer.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int LATENCY     = DEF_LATENCY,
    parameter int EMPTY_GUARD = DEF_EMPTY_GUARD
) (
    input  logic                clk,
    input  logic                reset,
    fifo_stream_reader_if.master bus
`ifdef FIFO_STREAM_READER_COUNT_EN
    ,
    output logic [COUNT_W-1:0]  out_count
`endif
);

    localparam int BUF_DEPTH = LATENCY + 1;
    localparam int OCC_W     = cnt_width(BUF_DEPTH);
    localparam int GUARD_W   = cnt_width(EMPTY_GUARD);
    localparam int CREDIT_W  = cnt_width(LATENCY + BUF_DEPTH);

    logic [LATENCY-1:0]  inflight_sr;
    logic [GUARD_W-1:0]  guard_cnt;
    logic [OCC_W-1:0]    occupancy;
    logic [CREDIT_W-1:0] inflight_cnt;
    logic [CREDIT_W-1:0] credit_used;
    logic                capture;
    logic                pop;
    logic                guard_done;
    logic                read_en;

    // The oldest inflight bit marks the edge where fifo_read_data holds that read's word.
    assign capture    = inflight_sr[LATENCY-1];
    assign pop        = bus.out_valid & bus.out_ready;
    assign guard_done = (guard_cnt == '0);

    // Count of reads issued but not yet returned.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < LATENCY; i++)
            inflight_cnt = inflight_cnt + CREDIT_W'(inflight_sr[i]);
    end

    // Slots already claimed once this cycle's pop is credited back.
    assign credit_used = inflight_cnt + CREDIT_W'(occupancy) - CREDIT_W'(pop);

    // Read strobe is combinational so it drops in the same cycle fifo_empty rises.
    assign read_en       = reset & ~bus.fifo_empty & guard_done
                         & (credit_used < CREDIT_W'(BUF_DEPTH));
    assign bus.fifo_read = read_en;
    assign bus.out_valid = (occupancy != '0);

    // Track outstanding reads: each edge shifts in the current strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            inflight_sr <= '0;
        else
            inflight_sr <= {inflight_sr[LATENCY-2:0], read_en};
    end

    // Guard holds off the first read until fifo_empty has stayed low long enough.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            guard_cnt <= GUARD_W'(EMPTY_GUARD);
        else if (bus.fifo_empty)
            guard_cnt <= GUARD_W'(EMPTY_GUARD);
        else if (!guard_done)
            guard_cnt <= guard_cnt - GUARD_W'(1);
    end

    stream_out_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data (bus.fifo_read_data),
        .pop       (pop),
        .pop_data  (bus.out_data),
        .occupancy (occupancy)
    );

`ifdef FIFO_STREAM_READER_COUNT_EN
    // Accepted-word counter, wraps naturally at its width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            out_count <= '0;
        else if (pop)
            out_count <= out_count + COUNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader with a fixed-latency FIFO model.
// Latency: model returns data LATENCY edges after a sampled read.
// Backpressure: directed out_ready patterns (held low, toggling, held high).
module tb_fifo_stream_reader;
    import fifo_stream_pkg::*;

    localparam int DW  = 8;
    localparam int LAT = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

`ifdef FIFO_STREAM_READER_COUNT_EN
    logic [COUNT_W-1:0] out_count;
`endif

    fifo_stream_reader #(
        .DATA_WIDTH  (DW),
        .LATENCY     (LAT),
        .EMPTY_GUARD (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FIFO_STREAM_READER_COUNT_EN
        ,
        .out_count (out_count)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] push_q [$];
    logic [DW-1:0] exp_q  [$];
    logic [DW-1:0] pipe   [LAT];

    logic [DW-1:0] words3 [20] = '{8'h3C, 8'hA7, 8'h11, 8'hF0, 8'h5E, 8'h82, 8'h09, 8'hCD,
                                   8'h74, 8'h2B, 8'hE1, 8'h6F, 8'h90, 8'h38, 8'hD4, 8'h47,
                                   8'hB9, 8'h1A, 8'h63, 8'hFE};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Upstream FIFO model: read sampled at an edge returns data LAT edges later.
    assign bus.fifo_read_data = pipe[LAT-1];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_q.delete();
            for (int i = 0; i < LAT; i++) pipe[i] <= 8'hEE;
            bus.fifo_empty <= 1'b1;
        end else begin
            for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            if (bus.fifo_read) pipe[0] <= fifo_q.pop_front();
            else               pipe[0] <= 8'hEE;
            while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
            bus.fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // Monitor: scoreboard pops, stall stability, no reads while empty.
    logic          stalled_prev = 1'b0;
    logic [DW-1:0] stall_data   = '0;
    always @(negedge clk) begin
        if (!reset) begin
            stalled_prev = 1'b0;
        end else begin
            if (bus.fifo_empty) check("read_while_empty", 32'(bus.fifo_read), 32'd0);
            if (stalled_prev) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_data", 32'(bus.out_data), 32'(stall_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                check("word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("stream_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
            end
            stalled_prev = bus.out_valid && !bus.out_ready;
            stall_data   = bus.out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        push_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain_in_time"}, 32'(n < budget), 32'd1);
    endtask

    // Cycles from fifo_empty seen low to the first fifo_read.
    task automatic measure_read_delay(output int d);
        int n = 0;
        while (bus.fifo_empty && n < 50) begin
            @(negedge clk);
            n++;
        end
        d = 0;
        while (!bus.fifo_read && d < 50) begin
            @(negedge clk);
            d++;
        end
    endtask

    initial begin
        int d, v, c, reads, seen, n;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_fifo_read", 32'(bus.fifo_read), 32'd0);
        check("rst_guard", 32'(dut.guard_cnt), 32'd2);
        check("rst_occupancy", 32'(dut.occupancy), 32'd0);
`ifdef FIFO_STREAM_READER_COUNT_EN
        check("rst_out_count", 32'(out_count), 32'd0);
`endif
        reset = 1'b1;
        repeat (2) tick();

        // Preloaded FIFO, sink always ready.
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(DW'(i));
        measure_read_delay(d);
        check("t1_read_delay", 32'(d), 32'd2);
        v = 0;
        while (!bus.out_valid && v < 50) begin
            @(negedge clk);
            v++;
        end
        check("t1_valid_delay", 32'(v), 32'd4);
        c = 0;
        while (bus.out_valid && c < 50) begin
            c++;
            @(negedge clk);
        end
        check("t1_consecutive", 32'(c), 32'd8);
        wait_drain(100, "t1");

        // Sink stalled: only BUF_DEPTH reads may be issued.
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_word(DW'(8'h10 + i));
        reads = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.fifo_read) reads++;
        end
        check("t2_reads", 32'(reads), 32'd4);
        check("t2_occupancy", 32'(dut.occupancy), 32'd4);
        check("t2_read_low", 32'(bus.fifo_read), 32'd0);
        tick();
        bus.out_ready = 1'b1;
        wait_drain(200, "t2");

        // Sink toggling every cycle.
        tick();
        for (int i = 0; i < 20; i++) push_word(words3[i]);
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
            tick();
            bus.out_ready = ~bus.out_ready;
            n++;
        end
        check("t3_drain_in_time", 32'(n < 300), 32'd1);
        bus.out_ready = 1'b1;
        repeat (3) tick();

        // FIFO runs dry mid-stream, then refills.
        for (int i = 0; i < 3; i++) push_word(DW'(8'h40 + i));
        n = 0;
        while (bus.fifo_empty && n < 50) begin @(negedge clk); n++; end
        while (!bus.fifo_empty && n < 100) begin @(negedge clk); n++; end
        check("t4_empty_seen", 32'(bus.fifo_empty), 32'd1);
        check("t4_read_drop", 32'(bus.fifo_read), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) push_word(DW'(8'h50 + i));
        measure_read_delay(d);
        check("t4_refill_delay", 32'(d), 32'd2);
        wait_drain(100, "t4");

        // Reset with words inflight and buffered.
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(DW'(8'hA0 + i));
        n = 0;
        while (dut.occupancy != 2 && n < 50) begin @(negedge clk); n++; end
        check("t5_reached_state", 32'(dut.occupancy), 32'd2);
        tick();
        reset = 1'b0;
        #1;
        check("t5_valid_cleared", 32'(bus.out_valid), 32'd0);
        check("t5_read_cleared", 32'(bus.fifo_read), 32'd0);
        check("t5_occ_cleared", 32'(dut.occupancy), 32'd0);
        exp_q.delete();
        push_q.delete();
        repeat (2) tick();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("t5_no_stale", 32'(seen), 32'd0);
        tick();
        push_word(8'h5A);
        push_word(8'hA5);
        wait_drain(100, "t5");

`ifdef FIFO_STREAM_READER_COUNT_EN
        // Counter wrap over a long transfer.
        tick();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 70000; i++) push_word(DW'(i));
        wait_drain(80000, "t6");
        check("t6_out_count", 32'(out_count), 32'd4464);
`endif

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
